// File: rtl/cp0_ctrl_pkg.sv
// rtl/cp0_ctrl_pkg.sv - CP0 register indices, exception codes and field packing helpers
package cp0_ctrl_pkg;

    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_SR       = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [4:0]  REG_PRID     = 5'd15;

    localparam logic [4:0]  EXC_INT  = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [4:0]  EXC_ADES = 5'd5;
    localparam logic [4:0]  EXC_RI   = 5'd10;
    localparam logic [4:0]  EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] PRID_VALUE   = 32'h2019_0305;

    function automatic logic [31:0] pack_sr(logic [5:0] im, logic exl, logic ie);
        return {16'b0, im, 8'b0, exl, ie};
    endfunction

    function automatic logic [31:0] pack_cause(logic bd, logic [5:0] ip, logic [4:0] exc);
        return {bd, 15'b0, ip, 3'b0, exc, 2'b0};
    endfunction

endpackage

// File: rtl/cp0_ctrl_if.sv
// rtl/cp0_ctrl_if.sv - pipeline-to-CP0 signal bundle; VAddrIn exists only with CP0_BADVADDR_EN
interface cp0_ctrl_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PCIn;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] DOut;
    logic [31:0] EPCOut;
    logic        Interrupt;
`ifdef CP0_BADVADDR_EN
    logic [31:0] VAddrIn;
`endif

    modport master (
        output A1, A2, DIn, WE, PCIn, BDIn, ExcCodeIn, HWInt, EXLClr,
`ifdef CP0_BADVADDR_EN
        output VAddrIn,
`endif
        input  DOut, EPCOut, Interrupt
    );

    modport slave (
        input  A1, A2, DIn, WE, PCIn, BDIn, ExcCodeIn, HWInt, EXLClr,
`ifdef CP0_BADVADDR_EN
        input  VAddrIn,
`endif
        output DOut, EPCOut, Interrupt
    );
endinterface

// File: rtl/cp0_int_arb.sv
// rtl/cp0_int_arb.sv - interrupt/exception request and priority; interrupts beat exceptions
module cp0_int_arb (
    input  logic [5:0] HWInt,
    input  logic [5:0] IM,
    input  logic       IE,
    input  logic       EXL,
    input  logic [4:0] ExcCodeIn,
    output logic       Interrupt,
    output logic [4:0] CauseCode
);
    import cp0_ctrl_pkg::*;

    logic int_req;
    logic exc_req;

    assign int_req   = (|(HWInt & IM)) & IE & ~EXL;
    assign exc_req   = (ExcCodeIn != 5'd0) & ~EXL;
    assign Interrupt = int_req | exc_req;
    assign CauseCode = int_req ? EXC_INT : ExcCodeIn;
endmodule

// File: rtl/cp0_ctrl.sv
// rtl/cp0_ctrl.sv - CP0 SR/Cause/EPC/PRId with exception entry; BadVAddr under CP0_BADVADDR_EN
module cp0_ctrl (
    input  logic       clk,
    input  logic       reset,
    cp0_ctrl_if.slave  bus
);
    import cp0_ctrl_pkg::*;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q, badvaddr_d;
`endif

    logic        irq;
    logic [4:0]  cause_code;
    logic [31:0] pc_base;

    cp0_int_arb u_arb (
        .HWInt     (bus.HWInt),
        .IM        (im_q),
        .IE        (ie_q),
        .EXL       (exl_q),
        .ExcCodeIn (bus.ExcCodeIn),
        .Interrupt (irq),
        .CauseCode (cause_code)
    );

    assign pc_base = bus.BDIn ? (bus.PCIn - 32'd4) : bus.PCIn;

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        ip_d  = bus.HWInt;
        exc_d = exc_q;
        epc_d = epc_q;
`ifdef CP0_BADVADDR_EN
        badvaddr_d = badvaddr_q;
`endif
        if (irq) begin
            exl_d = 1'b1;
            exc_d = cause_code;
            bd_d  = bus.BDIn;
            epc_d = pc_base & ~32'd3;
`ifdef CP0_BADVADDR_EN
            if (cause_code == EXC_ADEL || cause_code == EXC_ADES)
                badvaddr_d = bus.VAddrIn;
`endif
        end else begin
            // mtc0 is squashed by a same-cycle exception; eret then overrides the EXL bit
            if (bus.WE) begin
                if (bus.A2 == REG_SR) begin
                    im_d  = bus.DIn[15:10];
                    exl_d = bus.DIn[1];
                    ie_d  = bus.DIn[0];
                end else if (bus.A2 == REG_EPC) begin
                    epc_d = bus.DIn;
                end
            end
            if (bus.EXLClr)
                exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
`ifdef CP0_BADVADDR_EN
            badvaddr_q <= '0;
`endif
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
`ifdef CP0_BADVADDR_EN
            badvaddr_q <= badvaddr_d;
`endif
        end
    end

    always_comb begin
        bus.DOut = 32'd0;
        case (bus.A1)
            REG_SR:       bus.DOut = pack_sr(im_q, exl_q, ie_q);
            REG_CAUSE:    bus.DOut = pack_cause(bd_q, ip_q, exc_q);
            REG_EPC:      bus.DOut = epc_q;
            REG_PRID:     bus.DOut = PRID_VALUE;
`ifdef CP0_BADVADDR_EN
            REG_BADVADDR: bus.DOut = badvaddr_q;
`endif
            default:      bus.DOut = 32'd0;
        endcase
    end

    assign bus.EPCOut    = epc_q;
    assign bus.Interrupt = irq;
endmodule

// File: tb/tb_cp0_ctrl.sv
// tb/tb_cp0_ctrl.sv - randomized and directed bench for cp0_ctrl against a register-level model
`timescale 1ns/1ps
module tb_cp0_ctrl;
    logic clk;
    logic reset;
    cp0_ctrl_if bus ();

    cp0_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_sr, m_cause, m_epc;
    logic        model_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        case (idx)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h2019_0305;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_irq_req();
        return ((bus.HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_fire();
        return m_irq_req() || ((bus.ExcCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    // Register-level reference: whole 32-bit words with field masks
    always @(posedge clk) begin
        logic [31:0] nsr, ncause, nepc, pc;
        if (reset) begin
            m_sr <= 32'd0; m_cause <= 32'd0; m_epc <= 32'd0;
            model_en <= 1'b1;
        end else if (model_en) begin
            nsr    = m_sr;
            nepc   = m_epc;
            ncause = (m_cause & ~32'h0000_FC00) | (32'(bus.HWInt) << 10);
            if (m_fire()) begin
                nsr    = nsr | 32'h2;
                pc     = bus.BDIn ? bus.PCIn - 32'd4 : bus.PCIn;
                nepc   = pc & 32'hFFFF_FFFC;
                ncause = (ncause & 32'h0000_FC00) | (32'(bus.BDIn) << 31)
                       | (32'(m_irq_req() ? 5'd0 : bus.ExcCodeIn) << 2);
            end else begin
                if (bus.WE && bus.A2 == 5'd12) nsr  = bus.DIn & 32'h0000_FC03;
                if (bus.WE && bus.A2 == 5'd14) nepc = bus.DIn;
                if (bus.EXLClr) nsr = nsr & ~32'h2;
            end
            m_sr <= nsr; m_cause <= ncause; m_epc <= nepc;
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            check("dout",      bus.DOut,             m_read(bus.A1));
            check("epcout",    bus.EPCOut,           m_epc);
            check("interrupt", {31'd0, bus.Interrupt}, {31'd0, m_fire()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.WE = 1'b0; bus.ExcCodeIn = 5'd0; bus.HWInt = 6'd0;
        bus.EXLClr = 1'b0; bus.BDIn = 1'b0; reset = 1'b0;
    endtask

    task automatic expect_reg(input string name, input logic [4:0] idx, input logic [31:0] exp);
        bus.A1 = idx;
        #1;
        check(name, bus.DOut, exp);
    endtask

    task automatic expect_irq(input string name, input logic exp);
        #1;
        check(name, {31'd0, bus.Interrupt}, {31'd0, exp});
    endtask

    initial begin
        logic [4:0] idx_tab [6];
        idx_tab = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        bus.A1 = 5'd12; bus.A2 = 5'd0; bus.DIn = 32'd0; bus.PCIn = 32'h3000;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_reg("rst_sr", 5'd12, 32'd0);
        expect_reg("rst_cause", 5'd13, 32'd0);
        expect_reg("rst_epc", 5'd14, 32'd0);
        expect_irq("rst_irq", 1'b0);

        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
        tick();
        bus.WE = 1'b0;
        expect_reg("mtc0_sr", 5'd12, 32'h0000_0401);
        bus.HWInt = 6'b000001; bus.PCIn = 32'h0000_3000;
        expect_irq("hw_irq", 1'b1);
        tick();
        bus.HWInt = 6'd0;
        expect_reg("hw_sr", 5'd12, 32'h0000_0403);
        expect_reg("hw_cause", 5'd13, 32'h0000_0400);
        expect_reg("hw_epc", 5'd14, 32'h0000_3000);
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
        expect_reg("eret_sr", 5'd12, 32'h0000_0401);
        expect_reg("eret_cause", 5'd13, 32'd0);

        bus.ExcCodeIn = 5'd12; bus.PCIn = 32'h3008; bus.BDIn = 1'b1;
        expect_irq("ov_irq", 1'b1);
        tick();
        idle();
        expect_reg("ov_epc", 5'd14, 32'h0000_3004);
        expect_reg("ov_cause", 5'd13, 32'h8000_0030);
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;

        bus.HWInt = 6'b000001; bus.ExcCodeIn = 5'd10; bus.PCIn = 32'h3010;
        expect_irq("both_irq", 1'b1);
        tick();
        idle();
        expect_reg("both_cause", 5'd13, 32'h0000_0400);
        expect_reg("both_epc", 5'd14, 32'h0000_3010);

        bus.ExcCodeIn = 5'd4; bus.PCIn = 32'h3050;
        expect_irq("exl_mask", 1'b0);
        tick();
        idle();
        expect_reg("exl_epc", 5'd14, 32'h0000_3010);
        expect_reg("exl_sr", 5'd12, 32'h0000_0403);
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
        expect_reg("exlclr_sr", 5'd12, 32'h0000_0401);

        bus.ExcCodeIn = 5'd5; bus.PCIn = 32'h3022;
        bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h3abc;
        tick();
        idle();
        expect_reg("squash_epc", 5'd14, 32'h0000_3020);
        expect_reg("squash_cause", 5'd13, 32'h0000_0014);
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;

        bus.WE = 1'b1; bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
        tick();
        bus.A2 = 5'd14; bus.DIn = 32'h3abc;
        tick();
        bus.WE = 1'b0;
        expect_reg("cause_ro", 5'd13, 32'h0000_0014);
        expect_reg("mtc0_epc", 5'd14, 32'h0000_3abc);
        expect_reg("prid", 5'd15, 32'h2019_0305);
        expect_reg("idx8", 5'd8, 32'd0);

        bus.ExcCodeIn = 5'd12; reset = 1'b1;
        expect_irq("rst_race_irq", 1'b1);
        tick();
        idle();
        expect_reg("rst_race_sr", 5'd12, 32'd0);
        expect_reg("rst_race_cause", 5'd13, 32'd0);
        expect_reg("rst_race_epc", 5'd14, 32'd0);

        for (int i = 0; i < 600; i++) begin
            bus.A1        = idx_tab[$urandom_range(0, 5)];
            bus.A2        = idx_tab[$urandom_range(0, 5)];
            bus.DIn       = $urandom;
            bus.WE        = ($urandom_range(0, 2) == 0);
            bus.PCIn      = $urandom;
            bus.BDIn      = $urandom_range(0, 1);
            bus.ExcCodeIn = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            bus.HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            bus.EXLClr    = m_sr[1] && ($urandom_range(0, 2) == 0);
            reset         = ($urandom_range(0, 63) == 0);
            tick();
        end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
